// File: rtl/dma_stream_wr_ctrl.sv
// dma_stream_wr_ctrl: upstream control stage for the DMA write path.
// Takes a software-programmed transfer (byte base address and word count) and
// a valid/ready word stream. It cuts the transfer into bursts, presents each
// burst on the DMA native slave write port, and reports done/err for the
// whole transfer.
//
// Build option: define DMA_STREAM_4K_SPLIT_EN to also limit every burst so
// that it never crosses a 4 KB address boundary. When the macro is undefined,
// bursts are limited only by the remaining word count and MAX_BURST.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; only state with busy=0
// CALC     | size the next burst, register dma_len, clear beat counter
// WAIT_DMA | hold until the DMA is idle (dma_ready)
// XFER     | stream words through to the native port, one per handshake
// NEXT     | advance burst address and remaining count
// FIN      | wait for the last write response to drain, then pulse done

module dma_stream_wr_ctrl #(
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MAX_BURST  = 256,
    parameter int CNT_W      = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AXI_ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]          word_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic                      s_valid,
    input  logic [DMA_DATA_W-1:0]     s_data,
    output logic                      s_ready,
    output logic                      valid,
    output logic [AXI_ADDR_W-1:0]     address,
    output logic [DMA_DATA_W-1:0]     wdata,
    output logic [DMA_DATA_W/8-1:0]   wstrb,
    input  logic                      ready,
    output logic [AXI_LEN_W-1:0]      dma_len,
    input  logic                      dma_ready,
    input  logic                      dma_error
);

    localparam int BPW = DMA_DATA_W / 8;
    localparam int BSH = $clog2(BPW);
    // Beat arithmetic is done wide enough for the word count, the burst
    // length and the 13-bit distance to the next 4 KB boundary.
    localparam int BW0 = (CNT_W > AXI_LEN_W) ? CNT_W : AXI_LEN_W;
    localparam int BW  = ((BW0 > 13) ? BW0 : 13) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        WAIT_DMA = 3'd2,
        XFER     = 3'd3,
        NEXT     = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [AXI_LEN_W-1:0]  beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic [BW-1:0]         rem_ext;
    logic [BW-1:0]         max_ext;
    logic [BW-1:0]         beats_calc;
    logic [AXI_LEN_W:0]    burst_beats;
    logic                  beat_hs;

    assign rem_ext     = BW'(rem_q);
    assign max_ext     = BW'(MAX_BURST);
    assign burst_beats = {1'b0, len_q} + (AXI_LEN_W+1)'(1);
    assign beat_hs     = s_valid & ready;

`ifdef DMA_STREAM_4K_SPLIT_EN
    logic [12:0]   bytes_to_4k;
    logic [BW-1:0] lim_4k;

    assign bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    assign lim_4k      = BW'(bytes_to_4k >> BSH);

    // Burst size: smallest of remaining words, MAX_BURST and words to the 4 KB edge.
    always_comb begin
        beats_calc = (rem_ext < max_ext) ? rem_ext : max_ext;
        if (lim_4k < beats_calc) begin
            beats_calc = lim_4k;
        end
    end
`else
    // Burst size: smallest of remaining words and MAX_BURST.
    always_comb begin
        beats_calc = (rem_ext < max_ext) ? rem_ext : max_ext;
    end
`endif

    // Native port is a direct pass-through of the stream, gated to XFER.
    assign busy    = (state_q != IDLE);
    assign valid   = (state_q == XFER) & s_valid;
    assign s_ready = (state_q == XFER) & ready;
    assign wdata   = s_data;
    assign wstrb   = {BPW{valid}};
    assign address = addr_q;
    assign dma_len = len_q;
    assign done    = done_q;
    assign err     = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: burst address, remaining words, burst length, beat count, flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            len_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            len_q  <= len_d;
            beat_q <= beat_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        done_d  = 1'b0;

        // Errors are recorded but never abort the transfer.
        if ((state_q != IDLE) && dma_error) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_cnt;
                    err_d   = 1'b0;
                    state_d = (word_cnt == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                len_d   = AXI_LEN_W'(beats_calc - BW'(1));
                beat_d  = '0;
                state_d = WAIT_DMA;
            end
            WAIT_DMA: begin
                if (dma_ready) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_hs) begin
                    beat_d = beat_q + AXI_LEN_W'(1);
                    if (beat_q == len_q) begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                addr_d  = addr_q + (AXI_ADDR_W'(burst_beats) << BSH);
                rem_d   = rem_q - CNT_W'(burst_beats);
                state_d = (rem_d == '0) ? FIN : CALC;
            end
            FIN: begin
                if (dma_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_stream_wr_ctrl.sv
// Directed bench for dma_stream_wr_ctrl. A stream source feeds an indexed
// word sequence; a monitor rebuilds the bursts seen on the native port and
// the main sequence compares them with hand-computed expectations.
// Expectations for the 4 KB split follow DMA_STREAM_4K_SPLIT_EN.

module tb_dma_stream_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [23:0] word_cnt = '0;
    logic        busy, done, err;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready = 1'b0;
    logic [7:0]  dma_len;
    logic        dma_ready = 1'b0;
    logic        dma_error = 1'b0;

    dma_stream_wr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .valid     (valid),
        .address   (address),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .ready     (ready),
        .dma_len   (dma_len),
        .dma_ready (dma_ready),
        .dma_error (dma_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controls owned by the main sequence.
    logic [31:0] data_base = 32'hA000_0000;
    logic        rnd_mode = 1'b0;
    logic        err_arm = 1'b0;
    int          clr_epoch = 0;
    int          poke_k = 0;

    // Monitor state (owned by the monitor process).
    int          mon_epoch = 0;
    int          mon_beats = 0;
    int          mon_done = 0;
    int          mon_valid_cyc = 0;
    int          mon_sready_cyc = 0;
    int          bad_data = 0;
    int          bad_strb = 0;
    logic        hs_seen = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] b_addr[$];
    int          b_len[$];
    int          b_cnt[$];

    always @(negedge clk) begin
        if (mon_epoch != clr_epoch) begin
            mon_epoch = clr_epoch;
            mon_beats = 0; mon_done = 0; mon_valid_cyc = 0; mon_sready_cyc = 0;
            bad_data = 0; bad_strb = 0;
            b_addr.delete(); b_len.delete(); b_cnt.delete();
        end
        hs_seen = valid && ready;
        if (wstrb !== (valid ? 4'hF : 4'h0)) bad_strb++;
        if (valid) mon_valid_cyc++;
        if (s_ready) mon_sready_cyc++;
        if (done) mon_done++;
        if (valid && ready) begin
            if (wdata !== data_base + 32'(mon_beats)) bad_data++;
            if (mon_beats == 0 || address != last_addr) begin
                b_addr.push_back(address);
                b_len.push_back(int'(dma_len));
                b_cnt.push_back(1);
            end else begin
                b_cnt[b_cnt.size()-1]++;
            end
            last_addr = address;
            mon_beats++;
        end
    end

    // Stream source and DMA-side responder, updated just after each rising edge.
    int drv_epoch = 0;
    int src_idx = 0;
    logic err_fired = 1'b0;
    always @(posedge clk) begin
        #1;
        if (drv_epoch != clr_epoch) begin
            drv_epoch = clr_epoch;
            src_idx = 0;
        end else if (hs_seen) begin
            src_idx++;
        end
        s_data    = data_base + 32'(src_idx);
        s_valid   = rnd_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
        ready     = rnd_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
        dma_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!err_arm) err_fired = 1'b0;
        if (err_arm && !err_fired && mon_beats >= 5) begin
            dma_error = 1'b1;
            err_fired = 1'b1;
        end else begin
            dma_error = 1'b0;
        end
    end

    task automatic clear_stats(input logic [31:0] dbase);
        @(posedge clk);
        #3;
        clr_epoch++;
        data_base = dbase;
    endtask

    // Runs one transfer and returns the number of rising edges from the edge
    // that samples start to the edge that raises done. On the done cycle it can
    // raise start again so the next transfer begins coincident with done.
    task automatic run_xfer(input logic [31:0] base, input logic [23:0] wc, input bit pre_started,
                            input bit chain, input logic [31:0] nbase, input logic [23:0] nwc,
                            output int lat);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        if (!pre_started) begin
            @(posedge clk);
            #1;
            start = 1'b1; base_addr = base; word_cnt = wc;
        end
        while (!got && k < 4000) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 1) start = 1'b0;
            else if (k == poke_k) begin
                start = 1'b1; base_addr = 32'h5000; word_cnt = 24'd9;
            end else if (k == poke_k + 1) start = 1'b0;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        lat = k;
        check("done_seen", 32'(got), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        if (chain) begin
            start = 1'b1; base_addr = nbase; word_cnt = nwc;
        end
    endtask

    task automatic chk_burst(input string tag, input int i, input logic [31:0] ea, input int el);
        bool_present: begin end
        check({tag, "_addr"}, (i < b_addr.size()) ? b_addr[i] : 32'hDEAD_BEEF, ea);
        check({tag, "_len"}, (i < b_len.size()) ? 32'(b_len[i]) : 32'hDEAD_BEEF, 32'(el));
        check({tag, "_beats"}, (i < b_cnt.size()) ? 32'(b_cnt[i]) : 32'hDEAD_BEEF, 32'(el + 1));
    endtask

    task automatic post(input string tag, input int nbursts, input int nbeats, input int ndone);
        @(negedge clk);
        #1;
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_nbursts"}, 32'(b_addr.size()), 32'(nbursts));
        check({tag, "_nbeats"}, 32'(mon_beats), 32'(nbeats));
        check({tag, "_data"}, 32'(bad_data), 32'd0);
        check({tag, "_wstrb"}, 32'(bad_strb), 32'd0);
        check({tag, "_done_cnt"}, 32'(mon_done), 32'(ndone));
    endtask

    initial begin
        automatic int lat = 0;
        automatic int v0 = 0;
        automatic int r0 = 0;
        automatic bit reached = 1'b0;

        // Reset values
        #2;
        check("rst_addr", address, 32'd0);
        check("rst_ctl", {15'd0, busy, done, err, s_ready, valid, wstrb, dma_len}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // T1: four words in one burst; a start while busy must be ignored
        clear_stats(32'hA100_0000);
        poke_k = 4;
        run_xfer(32'h1000, 24'd4, 1'b0, 1'b0, 32'd0, 24'd0, lat);
        poke_k = 0;
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_end_addr", address, 32'h1010);
        post("t1", 1, 4, 1);
        chk_burst("t1_b0", 0, 32'h1000, 3);

        // T2: 600 words split at MAX_BURST
        clear_stats(32'hA200_0000);
        run_xfer(32'h0, 24'd600, 1'b0, 1'b0, 32'd0, 24'd0, lat);
        check("t2_latency", 32'(lat), 32'd611);
        check("t2_end_addr", address, 32'h960);
        post("t2", 3, 600, 1);
        chk_burst("t2_b0", 0, 32'h000, 255);
        chk_burst("t2_b1", 1, 32'h400, 255);
        chk_burst("t2_b2", 2, 32'h800, 87);

        // T3: 8 words starting 16 bytes below a 4 KB boundary
        clear_stats(32'hA300_0000);
        run_xfer(32'hFF0, 24'd8, 1'b0, 1'b0, 32'd0, 24'd0, lat);
        check("t3_end_addr", address, 32'h1010);
`ifdef DMA_STREAM_4K_SPLIT_EN
        check("t3_latency", 32'(lat), 32'd16);
        post("t3", 2, 8, 1);
        chk_burst("t3_b0", 0, 32'hFF0, 3);
        chk_burst("t3_b1", 1, 32'h1000, 3);
`else
        check("t3_latency", 32'(lat), 32'd13);
        post("t3", 1, 8, 1);
        chk_burst("t3_b0", 0, 32'hFF0, 7);
`endif

        // T4: address wraps past the top of the address space
        clear_stats(32'hA400_0000);
        run_xfer(32'hFFFF_FFF0, 24'd8, 1'b0, 1'b0, 32'd0, 24'd0, lat);
        check("t4_end_addr", address, 32'h10);
`ifdef DMA_STREAM_4K_SPLIT_EN
        check("t4_latency", 32'(lat), 32'd16);
        post("t4", 2, 8, 1);
        chk_burst("t4_b0", 0, 32'hFFFF_FFF0, 3);
        chk_burst("t4_b1", 1, 32'h0, 3);
`else
        check("t4_latency", 32'(lat), 32'd13);
        post("t4", 1, 8, 1);
        chk_burst("t4_b0", 0, 32'hFFFF_FFF0, 7);
`endif

        // T5: random stalls with a DMA error; chain a zero-length start onto done
        clear_stats(32'hA500_0000);
        rnd_mode = 1'b1;
        err_arm = 1'b1;
        run_xfer(32'h3000, 24'd20, 1'b0, 1'b1, 32'h4000, 24'd0, lat);
        rnd_mode = 1'b0;
        err_arm = 1'b0;
        check("t5_err_sticky", 32'(err), 32'd1);
        v0 = mon_valid_cyc;
        r0 = mon_sready_cyc;

        // T6: zero-length transfer started in the done cycle of T5
        run_xfer(32'h4000, 24'd0, 1'b1, 1'b0, 32'd0, 24'd0, lat);
        check("t6_latency", 32'(lat), 32'd2);
        check("t6_err_cleared", 32'(err), 32'd0);
        post("t5t6", 1, 20, 2);
        check("t6_no_valid", 32'(mon_valid_cyc - v0), 32'd0);
        check("t6_no_sready", 32'(mon_sready_cyc - r0), 32'd0);
        chk_burst("t5_b0", 0, 32'h3000, 19);

        // T7: reset after two of four beats
        clear_stats(32'hA700_0000);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 32'h1100; word_cnt = 24'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (mon_beats >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        check("t7_two_beats", 32'(reached), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t7_rst_addr", address, 32'd0);
        check("t7_rst_ctl", {15'd0, busy, done, err, s_ready, valid, wstrb, dma_len}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // T8: clean transfer after the reset
        clear_stats(32'hA800_0000);
        run_xfer(32'h2000, 24'd4, 1'b0, 1'b0, 32'd0, 24'd0, lat);
        check("t8_latency", 32'(lat), 32'd9);
        check("t8_end_addr", address, 32'h2010);
        post("t8", 1, 4, 1);
        chk_burst("t8_b0", 0, 32'h2000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
